sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Round-robin arbiter that funnels NUM_PORTS requesters onto one SDRAM
//   controller port. It allows one transfer in flight at a time. Each transfer
//   moves through three states:
//     IDLE  - pick the next pending port
//     ISSUE - forward that port's request downstream
//     WAIT  - wait for the matching completion, or abort on timeout
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   req_rd       per-port read request
//   req_wr       per-port write byte enables (nonzero = write request)
//   req_addr     per-port byte address, port p at slice p
//   req_wdata    per-port write data, port p at slice p
//   req_rdy      acceptance strobe for the granted port (one-hot or zero)
//   req_rvalid   read completion pulse to the granted port
//   req_wvalid   write completion pulse to the granted port
//   req_rdata    shared read data, zero unless req_rvalid is set
//   req_error    timeout pulse to the granted port
//   mem_rd/mem_wr/mem_addr/mem_wdata   downstream request of the granted port
//   mem_rdy      downstream acceptance
//   mem_rvalid/mem_wvalid/mem_rdata    downstream completions and read data
module sdram_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 24,
   parameter int TIMEOUT    = 255
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_PORTS-1:0]                req_rd,
   input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   req_wr,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
   output logic [NUM_PORTS-1:0]                req_rdy,
   output logic [NUM_PORTS-1:0]                req_rvalid,
   output logic [NUM_PORTS-1:0]                req_wvalid,
   output logic [DATA_WIDTH-1:0]               req_rdata,
   output logic [NUM_PORTS-1:0]                req_error,
   output logic                                mem_rd,
   output logic [DATA_WIDTH/8-1:0]             mem_wr,
   output logic [ADDR_WIDTH-1:0]               mem_addr,
   output logic [DATA_WIDTH-1:0]               mem_wdata,
   input  logic                                mem_rdy,
   input  logic                                mem_rvalid,
   input  logic                                mem_wvalid,
   input  logic [DATA_WIDTH-1:0]               mem_rdata
);

   localparam int BE_W = DATA_WIDTH / 8;
   localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            op_rd_q, op_rd_d;

   logic [NUM_PORTS-1:0] pending;
   logic                 rr_found;
   logic [PW-1:0]        rr_sel;
   logic [PW-1:0]        next_ptr;
   logic                 g_pend;
   logic                 g_rd;
   logic [BE_W-1:0]      g_wr;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [DATA_WIDTH-1:0] g_wdata;

   // A port is pending on a read strobe or on any write byte enable.
   always_comb begin
      pending = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         pending[p] = req_rd[p] | (|req_wr[p*BE_W +: BE_W]);
      end
   end

   // First pending port at or after ptr_q, wrapping around the port count.
   always_comb begin
      int unsigned idx;
      rr_found = 1'b0;
      rr_sel   = '0;
      idx      = 0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = (32'(ptr_q) + i) % NUM_PORTS;
         if (!rr_found && pending[idx]) begin
            rr_found = 1'b1;
            rr_sel   = PW'(idx);
         end
      end
   end

   assign next_ptr = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

   assign g_pend  = pending[grant_q];
   assign g_rd    = req_rd[grant_q];
   assign g_wr    = req_wr[grant_q*BE_W +: BE_W];
   assign g_addr  = req_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
   assign g_wdata = req_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];

   // Next-state and output decode. The request path in ISSUE and the
   // completion path in WAIT stay combinational so that acceptance and
   // completion are signalled in the same cycle as the downstream event.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      op_rd_d    = op_rd_q;
      req_rdy    = '0;
      req_rvalid = '0;
      req_wvalid = '0;
      req_rdata  = '0;
      req_error  = '0;
      mem_rd     = 1'b0;
      mem_wr     = '0;
      mem_addr   = '0;
      mem_wdata  = '0;

      case (state_q)
         S_IDLE: begin
            if (rr_found) begin
               grant_d = rr_sel;
               state_d = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (g_pend) begin
               mem_rd           = g_rd;
               mem_wr           = g_wr;
               mem_addr         = g_addr;
               mem_wdata        = g_wdata;
               req_rdy[grant_q] = mem_rdy;
               if (mem_rdy) begin
                  // A combined read+write completes as a read.
                  op_rd_d = g_rd;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end
            end else begin
               // Requester withdrew before acceptance; ptr is left alone
               // so no other port loses its turn.
               state_d = S_IDLE;
            end
         end

         S_WAIT: begin
            if (op_rd_q && mem_rvalid) begin
               req_rvalid[grant_q] = 1'b1;
               req_rdata           = mem_rdata;
               ptr_d               = next_ptr;
               state_d             = S_IDLE;
            end else if (!op_rd_q && mem_wvalid) begin
               req_wvalid[grant_q] = 1'b1;
               ptr_d               = next_ptr;
               state_d             = S_IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // cnt_q is zero on the first WAIT cycle, so this fires on
               // WAIT cycle number TIMEOUT.
               req_error[grant_q] = 1'b1;
               ptr_d              = next_ptr;
               state_d            = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are held quiet while reset is applied, even mid-transfer.
      if (rst) begin
         req_rdy    = '0;
         req_rvalid = '0;
         req_wvalid = '0;
         req_rdata  = '0;
         req_error  = '0;
         mem_rd     = 1'b0;
         mem_wr     = '0;
         mem_addr   = '0;
         mem_wdata  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         op_rd_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         op_rd_q <= op_rd_d;
      end
   end

endmodule
